// File: rtl/hazard_control_unit.sv
// hazard_control_unit
// Front-end hazard resolution for the 5-stage RV32IM pipeline: load-use
// stalls, multi-cycle MUL/DIV occupancy of EX, data-memory wait freezes and
// taken branch/jump flushes. Drives the advance enables, bubbles and flushes
// of PC, IF/ID, ID/EX and EX/MEM.
// Optional build macro: HAZARD_PERF_CNT_EN adds saturating 32-bit stall and
// flush performance counters; without it PERF_STALLS/PERF_FLUSHES read 0.
module hazard_control_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 33,
  parameter int CNT_W      = $clog2(DIV_CYCLES + 1)
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [REG_ADDR_W-1:0] ID_RS1,
  input  logic [REG_ADDR_W-1:0] ID_RS2,
  input  logic                  ID_USES_RS1,
  input  logic                  ID_USES_RS2,
  input  logic [REG_ADDR_W-1:0] EX_RD,
  input  logic                  EX_MemRead,
  input  logic                  EX_IS_MDU,
  input  logic                  EX_IS_DIV,
  input  logic                  EX_BRANCH_TAKEN,
  input  logic                  MEM_WAIT,
  output logic                  PCWrite,
  output logic                  IF_ID_Write,
  output logic                  ID_EX_Write,
  output logic                  EX_MEM_Write,
  output logic                  Stall_ID_EX,
  output logic                  Bubble_EX_MEM,
  output logic                  Flush_IF_ID,
  output logic                  MDU_Busy,
  output logic [1:0]            STALL_CAUSE,
  output logic [31:0]           PERF_STALLS,
  output logic [31:0]           PERF_FLUSHES
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'd0,
    CAUSE_MEM_WAIT = 2'd1,
    CAUSE_MDU      = 2'd2,
    CAUSE_LOAD_USE = 2'd3
  } cause_e;

  // An op needs the FSM only when it occupies EX for more than one cycle.
  // The counter is loaded with LAT-2: the first hold cycle is spent in IDLE
  // and the release cycle is spent in RUN with the counter at zero.
  localparam logic             MUL_MULTI = (MUL_CYCLES > 1);
  localparam logic             DIV_MULTI = (DIV_CYCLES > 1);
  localparam logic [CNT_W-1:0] MUL_LOAD  = (MUL_CYCLES > 1) ? CNT_W'(MUL_CYCLES - 2) : '0;
  localparam logic [CNT_W-1:0] DIV_LOAD  = (DIV_CYCLES > 1) ? CNT_W'(DIV_CYCLES - 2) : '0;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             lat_multi;
  logic [CNT_W-1:0] lat_load;
  logic             load_use;
  logic             mdu_hold;
  cause_e           cause;

  // Hazard conditions decoded from the current EX/ID contents and FSM state.
  always_comb begin
    lat_multi = EX_IS_DIV ? DIV_MULTI : MUL_MULTI;
    lat_load  = EX_IS_DIV ? DIV_LOAD  : MUL_LOAD;
    // x0 is never a real dependency, and an operand the ID instruction does
    // not read cannot create one.
    load_use  = EX_MemRead && (EX_RD != '0) &&
                ((ID_USES_RS1 && (EX_RD == ID_RS1)) ||
                 (ID_USES_RS2 && (EX_RD == ID_RS2)));
    mdu_hold  = ((state_q == IDLE) && EX_IS_MDU && lat_multi) ||
                ((state_q == RUN)  && (cnt_q != '0));
  end

  // MDU occupancy FSM next state; a memory wait freezes it in place.
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!MEM_WAIT) begin
      unique case (state_q)
        IDLE: begin
          if (EX_IS_MDU && lat_multi) begin
            cnt_d   = lat_load;
            state_d = RUN;
          end
        end
        RUN: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else begin
            // Release cycle: the result advances into EX/MEM now.
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM state and occupancy counter registers.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples pre-edge values regardless of statement order.
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Pipeline control decode, highest-priority hazard wins.
  always_comb begin
    PCWrite       = 1'b1;
    IF_ID_Write   = 1'b1;
    ID_EX_Write   = 1'b1;
    EX_MEM_Write  = 1'b1;
    Stall_ID_EX   = 1'b0;
    Bubble_EX_MEM = 1'b0;
    Flush_IF_ID   = 1'b0;
    cause         = CAUSE_NONE;
    if (!RESET) begin
      if (MEM_WAIT) begin
        // Freeze everything; a taken branch in EX is acted on after the wait.
        PCWrite      = 1'b0;
        IF_ID_Write  = 1'b0;
        ID_EX_Write  = 1'b0;
        EX_MEM_Write = 1'b0;
        cause        = CAUSE_MEM_WAIT;
      end else if (mdu_hold) begin
        // The MDU op keeps EX; younger stages hold, EX/MEM sees bubbles.
        PCWrite       = 1'b0;
        IF_ID_Write   = 1'b0;
        ID_EX_Write   = 1'b0;
        Bubble_EX_MEM = 1'b1;
        cause         = CAUSE_MDU;
      end else if (EX_BRANCH_TAKEN) begin
        // The ID instruction is squashed, so any load-use match is moot.
        Flush_IF_ID = 1'b1;
        Stall_ID_EX = 1'b1;
      end else if (load_use) begin
        PCWrite     = 1'b0;
        IF_ID_Write = 1'b0;
        Stall_ID_EX = 1'b1;
        cause       = CAUSE_LOAD_USE;
      end
    end
  end

  assign STALL_CAUSE = cause;
  assign MDU_Busy    = !RESET && (state_q == RUN);

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_stalls_q;
  logic [31:0] perf_flushes_q;

  // Saturating stall/flush event counters.
  always_ff @(posedge CLK) begin
    // NOTE: counters are control state and are cleared by reset; nothing
    // here is a storage array that could be left unreset.
    if (RESET) begin
      perf_stalls_q  <= '0;
      perf_flushes_q <= '0;
    end else begin
      if ((cause != CAUSE_NONE) && (perf_stalls_q != 32'hFFFF_FFFF)) begin
        perf_stalls_q <= perf_stalls_q + 32'd1;
      end
      if (Flush_IF_ID && (perf_flushes_q != 32'hFFFF_FFFF)) begin
        perf_flushes_q <= perf_flushes_q + 32'd1;
      end
    end
  end

  assign PERF_STALLS  = perf_stalls_q;
  assign PERF_FLUSHES = perf_flushes_q;
`else
  assign PERF_STALLS  = 32'd0;
  assign PERF_FLUSHES = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Self-checking bench for hazard_control_unit: directed scenarios with
// constant expectations, then randomized traffic against a behavioural model
// that tracks how many cycles the current MDU op has spent in EX.
module tb_hazard_control_unit;

  localparam int RW   = 5;
  localparam int MULC = 2;
  localparam int DIVC = 33;

  // Observed vector: {PCWrite, IF_ID_Write, ID_EX_Write, EX_MEM_Write,
  //                   Stall_ID_EX, Bubble_EX_MEM, Flush_IF_ID, MDU_Busy, STALL_CAUSE}
  localparam logic [9:0] DEF  = 10'b1111_000_0_00;
  localparam logic [9:0] LUX  = 10'b0011_100_0_11;
  localparam logic [9:0] BRX  = 10'b1111_101_0_00;
  localparam logic [9:0] BRB  = 10'b1111_101_1_00;
  localparam logic [9:0] HLD0 = 10'b0001_010_0_10;
  localparam logic [9:0] HLD1 = 10'b0001_010_1_10;
  localparam logic [9:0] REL  = 10'b1111_000_1_00;
  localparam logic [9:0] WT0  = 10'b0000_000_0_01;
  localparam logic [9:0] WT1  = 10'b0000_000_1_01;

  logic          CLK = 1'b0;
  logic          RESET;
  logic [RW-1:0] ID_RS1, ID_RS2, EX_RD;
  logic          ID_USES_RS1, ID_USES_RS2;
  logic          EX_MemRead, EX_IS_MDU, EX_IS_DIV, EX_BRANCH_TAKEN, MEM_WAIT;

  logic        PCWrite, IF_ID_Write, ID_EX_Write, EX_MEM_Write;
  logic        Stall_ID_EX, Bubble_EX_MEM, Flush_IF_ID, MDU_Busy;
  logic [1:0]  STALL_CAUSE;
  logic [31:0] PERF_STALLS, PERF_FLUSHES;

  logic        pc_w1, ifid_w1, idex_w1, exmem_w1, stall1, bubble1, flush1, busy1;
  logic [1:0]  cause1;
  logic [31:0] perf_s1, perf_f1;

  logic [9:0] obs, obs1;
  assign obs  = {PCWrite, IF_ID_Write, ID_EX_Write, EX_MEM_Write,
                 Stall_ID_EX, Bubble_EX_MEM, Flush_IF_ID, MDU_Busy, STALL_CAUSE};
  assign obs1 = {pc_w1, ifid_w1, idex_w1, exmem_w1, stall1, bubble1, flush1, busy1, cause1};

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model state
  int          m_age;      // non-wait cycles the current MDU op has spent in EX
  int          m_lat;      // latency of that op
  logic        m_div;
  logic [31:0] m_stalls, m_flushes;

  always #5 CLK = ~CLK;

  hazard_control_unit #(.REG_ADDR_W(RW), .MUL_CYCLES(MULC), .DIV_CYCLES(DIVC)) dut (
    .CLK(CLK), .RESET(RESET),
    .ID_RS1(ID_RS1), .ID_RS2(ID_RS2), .ID_USES_RS1(ID_USES_RS1), .ID_USES_RS2(ID_USES_RS2),
    .EX_RD(EX_RD), .EX_MemRead(EX_MemRead), .EX_IS_MDU(EX_IS_MDU), .EX_IS_DIV(EX_IS_DIV),
    .EX_BRANCH_TAKEN(EX_BRANCH_TAKEN), .MEM_WAIT(MEM_WAIT),
    .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write), .ID_EX_Write(ID_EX_Write),
    .EX_MEM_Write(EX_MEM_Write), .Stall_ID_EX(Stall_ID_EX), .Bubble_EX_MEM(Bubble_EX_MEM),
    .Flush_IF_ID(Flush_IF_ID), .MDU_Busy(MDU_Busy), .STALL_CAUSE(STALL_CAUSE),
    .PERF_STALLS(PERF_STALLS), .PERF_FLUSHES(PERF_FLUSHES)
  );

  // Single-cycle multiplier variant: MUL ops must never stall.
  hazard_control_unit #(.REG_ADDR_W(RW), .MUL_CYCLES(1), .DIV_CYCLES(DIVC)) dut_mul1 (
    .CLK(CLK), .RESET(RESET),
    .ID_RS1(ID_RS1), .ID_RS2(ID_RS2), .ID_USES_RS1(ID_USES_RS1), .ID_USES_RS2(ID_USES_RS2),
    .EX_RD(EX_RD), .EX_MemRead(EX_MemRead), .EX_IS_MDU(EX_IS_MDU), .EX_IS_DIV(EX_IS_DIV),
    .EX_BRANCH_TAKEN(EX_BRANCH_TAKEN), .MEM_WAIT(MEM_WAIT),
    .PCWrite(pc_w1), .IF_ID_Write(ifid_w1), .ID_EX_Write(idex_w1),
    .EX_MEM_Write(exmem_w1), .Stall_ID_EX(stall1), .Bubble_EX_MEM(bubble1),
    .Flush_IF_ID(flush1), .MDU_Busy(busy1), .STALL_CAUSE(cause1),
    .PERF_STALLS(perf_s1), .PERF_FLUSHES(perf_f1)
  );

  task automatic clear_inputs();
    ID_RS1 = '0; ID_RS2 = '0; ID_USES_RS1 = 1'b0; ID_USES_RS2 = 1'b0;
    EX_RD = '0; EX_MemRead = 1'b0; EX_IS_MDU = 1'b0; EX_IS_DIV = 1'b0;
    EX_BRANCH_TAKEN = 1'b0; MEM_WAIT = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    clear_inputs();
    EX_MemRead = 1'b1; EX_RD = RW'(5); ID_RS1 = RW'(5); ID_USES_RS1 = 1'b1;
    EX_IS_MDU = 1'b1; EX_BRANCH_TAKEN = 1'b1; MEM_WAIT = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK); #1;
    n_checks++; if (obs !== DEF) $display("FAIL reset_outputs: got %b want %b", obs, DEF); else n_pass++;
    n_checks++; if (obs1 !== DEF) $display("FAIL reset_outputs_mul1: got %b want %b", obs1, DEF); else n_pass++;
    n_checks++;
    if (PERF_STALLS !== 32'd0 || PERF_FLUSHES !== 32'd0)
      $display("FAIL reset_perf: got %0d/%0d want 0/0", PERF_STALLS, PERF_FLUSHES);
    else n_pass++;
    RESET = 1'b0;
    clear_inputs();
  endtask

  task automatic test_load_use();
    int         rd_t [6] = '{5, 0, 5, 7, 7, 5};
    int         r1_t [6] = '{5, 0, 5, 1, 1, 5};
    int         r2_t [6] = '{0, 0, 0, 7, 7, 0};
    logic       u1_t [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic       u2_t [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic       mr_t [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [9:0] e_t  [6] = '{LUX, DEF, DEF, LUX, DEF, DEF};
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      clear_inputs();
      EX_RD = RW'(rd_t[i]); ID_RS1 = RW'(r1_t[i]); ID_RS2 = RW'(r2_t[i]);
      ID_USES_RS1 = u1_t[i]; ID_USES_RS2 = u2_t[i]; EX_MemRead = mr_t[i];
      #1;
      n_checks++; if (obs !== e_t[i]) $display("FAIL load_use[%0d]: got %b want %b", i, obs, e_t[i]); else n_pass++;
    end
    @(negedge CLK); clear_inputs();
  endtask

  task automatic test_div_occupancy();
    int         hold = 0, busy = 0;
    logic       released = 1'b0, first_busy = 1'b1;
    logic [9:0] rel_obs = '0;
    EX_IS_MDU = 1'b1; EX_IS_DIV = 1'b1;
    #1;
    for (int c = 1; c <= 100 && !released; c++) begin
      if (c > 1) begin @(negedge CLK); #1; end
      if (c == 1) first_busy = MDU_Busy;
      if (MDU_Busy === 1'b1) busy++;
      if (obs[9:2] === HLD0[9:2] || obs[9:2] === HLD1[9:2]) hold++;
      else if (obs[9:6] === 4'b1111) begin released = 1'b1; rel_obs = obs; end
    end
    n_checks++; if (!released) $display("FAIL div_release_timeout: got none want release within 100 cycles"); else n_pass++;
    n_checks++; if (hold != DIVC - 1) $display("FAIL div_hold_cycles: got %0d want %0d", hold, DIVC - 1); else n_pass++;
    n_checks++; if (busy != DIVC - 1) $display("FAIL div_busy_cycles: got %0d want %0d", busy, DIVC - 1); else n_pass++;
    n_checks++; if (first_busy !== 1'b0) $display("FAIL div_busy_cycle1: got %b want 0", first_busy); else n_pass++;
    n_checks++; if (rel_obs !== REL) $display("FAIL div_release_outputs: got %b want %b", rel_obs, REL); else n_pass++;
    @(negedge CLK); clear_inputs(); #1;
    n_checks++; if (obs !== DEF) $display("FAIL div_after_release: got %b want %b", obs, DEF); else n_pass++;
  endtask

  task automatic test_mul_occupancy();
    logic [9:0] e_t [2] = '{HLD0, REL};
    for (int c = 0; c < 2; c++) begin
      @(negedge CLK); clear_inputs(); EX_IS_MDU = 1'b1; #1;
      n_checks++; if (obs !== e_t[c]) $display("FAIL mul_cycle[%0d]: got %b want %b", c, obs, e_t[c]); else n_pass++;
      n_checks++; if (obs1 !== DEF) $display("FAIL mul1_no_stall[%0d]: got %b want %b", c, obs1, DEF); else n_pass++;
    end
    @(negedge CLK); clear_inputs();
  endtask

  task automatic test_back_to_back();
    logic [9:0] e_t [5] = '{HLD0, REL, HLD0, REL, DEF};
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK); clear_inputs(); EX_IS_MDU = (c < 4); #1;
      n_checks++; if (obs !== e_t[c]) $display("FAIL back_to_back[%0d]: got %b want %b", c, obs, e_t[c]); else n_pass++;
    end
    @(negedge CLK); clear_inputs();
  endtask

  task automatic test_mem_wait_in_div();
    int   hold = 0, waits = 0;
    logic released = 1'b0;
    for (int c = 1; c <= 100 && !released; c++) begin
      @(negedge CLK);
      clear_inputs(); EX_IS_MDU = 1'b1; EX_IS_DIV = 1'b1;
      MEM_WAIT = (c >= 10 && c <= 12);
      #1;
      if (obs === WT1) waits++;
      if (ID_EX_Write === 1'b0) hold++;
      else if (obs === REL) released = 1'b1;
    end
    n_checks++; if (!released) $display("FAIL memwait_release_timeout: got none want release within 100 cycles"); else n_pass++;
    n_checks++; if (waits != 3) $display("FAIL memwait_freeze_cycles: got %0d want 3", waits); else n_pass++;
    n_checks++; if (hold != 35) $display("FAIL memwait_hold_cycles: got %0d want 35", hold); else n_pass++;
    @(negedge CLK); clear_inputs();
  endtask

  task automatic test_branch_priority();
    // branch + load-use, branch under wait, branch after wait, MDU hold + branch, release + branch
    logic       w_t  [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic       m_t  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [9:0] e_t  [5] = '{BRX, WT0, BRX, HLD0, BRB};
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      clear_inputs();
      EX_BRANCH_TAKEN = 1'b1; MEM_WAIT = w_t[i]; EX_IS_MDU = m_t[i];
      EX_MemRead = !m_t[i]; EX_RD = RW'(3); ID_RS2 = RW'(3); ID_USES_RS2 = 1'b1;
      #1;
      n_checks++; if (obs !== e_t[i]) $display("FAIL branch_priority[%0d]: got %b want %b", i, obs, e_t[i]); else n_pass++;
    end
    @(negedge CLK); clear_inputs();
  endtask

  task automatic test_reset_in_run();
    for (int c = 1; c <= 25; c++) begin
      @(negedge CLK); clear_inputs(); EX_IS_MDU = 1'b1; EX_IS_DIV = 1'b1;
    end
    #1;
    n_checks++; if (obs !== HLD1) $display("FAIL rst_run_before: got %b want %b", obs, HLD1); else n_pass++;
    @(negedge CLK); RESET = 1'b1; #1;
    n_checks++; if (obs !== DEF) $display("FAIL rst_run_during: got %b want %b", obs, DEF); else n_pass++;
    @(negedge CLK); RESET = 1'b0; clear_inputs(); #1;
    n_checks++; if (obs !== DEF) $display("FAIL rst_run_after: got %b want %b", obs, DEF); else n_pass++;
    @(negedge CLK); #1;
    n_checks++; if (obs !== DEF) $display("FAIL rst_run_settled: got %b want %b", obs, DEF); else n_pass++;
  endtask

`ifdef HAZARD_PERF_CNT_EN
  task automatic test_perf();
    @(negedge CLK); RESET = 1'b1; clear_inputs();
    @(negedge CLK); RESET = 1'b0;
    for (int c = 0; c < 7; c++) begin
      @(negedge CLK); clear_inputs();
      if (c < 5) begin EX_MemRead = 1'b1; EX_RD = RW'(9); ID_RS1 = RW'(9); ID_USES_RS1 = 1'b1; end
      else EX_BRANCH_TAKEN = 1'b1;
    end
    @(negedge CLK); clear_inputs(); #1;
    n_checks++; if (PERF_STALLS !== 32'd5) $display("FAIL perf_stalls: got %0d want 5", PERF_STALLS); else n_pass++;
    n_checks++; if (PERF_FLUSHES !== 32'd2) $display("FAIL perf_flushes: got %0d want 2", PERF_FLUSHES); else n_pass++;
    @(negedge CLK);
    force dut.perf_stalls_q = 32'hFFFF_FFFF;
    EX_MemRead = 1'b1; EX_RD = RW'(9); ID_RS1 = RW'(9); ID_USES_RS1 = 1'b1;
    #1 release dut.perf_stalls_q;
    @(negedge CLK); clear_inputs(); #1;
    n_checks++; if (PERF_STALLS !== 32'hFFFF_FFFF) $display("FAIL perf_saturate: got %h want ffffffff", PERF_STALLS); else n_pass++;
  endtask
`endif

  // Expected outputs from the hazard rules and the op's elapsed EX cycles.
  function automatic logic model_hold();
    int lat = EX_IS_DIV ? DIVC : MULC;
    if (m_age > 0) return (m_age < m_lat - 1);
    return EX_IS_MDU && (lat > 1);
  endfunction

  function automatic logic [9:0] model_expect();
    logic busy = (m_age > 0);
    logic lu   = EX_MemRead && (EX_RD != 0) &&
                 ((ID_USES_RS1 && EX_RD == ID_RS1) || (ID_USES_RS2 && EX_RD == ID_RS2));
    if (RESET)           return DEF;
    if (MEM_WAIT)        return {8'b0000_000_0, 2'd1} | {7'b0, busy, 2'b00};
    if (model_hold())    return {8'b0001_010_0, 2'd2} | {7'b0, busy, 2'b00};
    if (EX_BRANCH_TAKEN) return {8'b1111_101_0, 2'd0} | {7'b0, busy, 2'b00};
    if (lu)              return {8'b0011_100_0, 2'd3} | {7'b0, busy, 2'b00};
    return {8'b1111_000_0, 2'd0} | {7'b0, busy, 2'b00};
  endfunction

  task automatic test_random();
    logic [9:0] exp_v;
    logic       hold;
    @(negedge CLK); RESET = 1'b1; clear_inputs();
    m_age = 0; m_lat = 0; m_div = 1'b0; m_stalls = '0; m_flushes = '0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge CLK);
      RESET = ($urandom_range(0, 99) < 2);
      if (m_age > 0) begin
        EX_IS_MDU = 1'b1; EX_IS_DIV = m_div;
      end else begin
        EX_IS_MDU = ($urandom_range(0, 99) < 10);
        EX_IS_DIV = EX_IS_MDU && ($urandom_range(0, 99) < 30);
      end
      EX_MemRead      = !EX_IS_MDU && ($urandom_range(0, 99) < 50);
      EX_RD           = RW'($urandom_range(0, 3));
      ID_RS1          = RW'($urandom_range(0, 3));
      ID_RS2          = RW'($urandom_range(0, 3));
      ID_USES_RS1     = ($urandom_range(0, 1) == 1);
      ID_USES_RS2     = ($urandom_range(0, 1) == 1);
      EX_BRANCH_TAKEN = ($urandom_range(0, 99) < 15);
      MEM_WAIT        = ($urandom_range(0, 99) < 15);
      #1;
      exp_v = model_expect();
      hold  = model_hold();
      n_checks++; if (obs !== exp_v) $display("FAIL random[%0d]: got %b want %b", c, obs, exp_v); else n_pass++;
`ifdef HAZARD_PERF_CNT_EN
      n_checks++;
      if (PERF_STALLS !== m_stalls || PERF_FLUSHES !== m_flushes)
        $display("FAIL random_perf[%0d]: got %0d/%0d want %0d/%0d", c, PERF_STALLS, PERF_FLUSHES, m_stalls, m_flushes);
      else n_pass++;
`endif
      if (RESET) begin
        m_age = 0; m_stalls = '0; m_flushes = '0;
      end else begin
        if (exp_v[1:0] != 2'd0 && m_stalls != 32'hFFFF_FFFF) m_stalls++;
        if (exp_v[3] && m_flushes != 32'hFFFF_FFFF) m_flushes++;
        if (!MEM_WAIT) begin
          if (hold) begin
            if (m_age == 0) begin m_lat = EX_IS_DIV ? DIVC : MULC; m_div = EX_IS_DIV; end
            m_age++;
          end else begin
            m_age = 0;
          end
        end
      end
    end
    @(negedge CLK); RESET = 1'b0; clear_inputs(); #1;
`ifndef HAZARD_PERF_CNT_EN
    n_checks++;
    if (PERF_STALLS !== 32'd0 || PERF_FLUSHES !== 32'd0)
      $display("FAIL perf_tied_off: got %0d/%0d want 0/0", PERF_STALLS, PERF_FLUSHES);
    else n_pass++;
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RESET = 1'b1;
    clear_inputs();
    test_reset();
    test_load_use();
    test_div_occupancy();
    test_mul_occupancy();
    test_back_to_back();
    test_mem_wait_in_div();
    test_branch_priority();
    test_reset_in_run();
`ifdef HAZARD_PERF_CNT_EN
    test_perf();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
